// File: rtl/raster_scan_writer.sv
// Raster scan engine: sweeps a pixel window, pairs coverage answers with addr/colour, writes the framebuffer.
// Latency: first write FILL_LATENCY+2 cycles after accept; job_done FILL_LATENCY+2 cycles after the last pixel.
// Backpressure: none downstream; one job at a time, job_ready only while idle.
// Build option: define RASTER_SCAN_BBOX_CLIP_EN to scan the job bounding box instead of the full frame.
//
// Per-job cycle budget, counted from the accept cycle:
//   1 accept cycle, N scan cycles, then FILL_LATENCY+2 drain cycles.
//   The first FILL_LATENCY+1 drain cycles retire the last write slot.
//   The final drain cycle carries job_done, so a held job_valid is taken exactly one cycle after job_done.
module raster_scan_writer #(
    parameter int FRAME_WIDTH  = 512,
    parameter int FRAME_HEIGHT = 384,
    parameter int COORD_W      = 16,
    parameter int COLOR_W      = 16,
    parameter int FILL_LATENCY = 3,
    parameter int ADDR_W       = $clog2(FRAME_WIDTH * FRAME_HEIGHT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic               job_clear,
    input  logic [COLOR_W-1:0] job_color,
    input  logic [COORD_W-1:0] job_xmin,
    input  logic [COORD_W-1:0] job_xmax,
    input  logic [COORD_W-1:0] job_ymin,
    input  logic [COORD_W-1:0] job_ymax,
    output logic               scan_valid,
    output logic [COORD_W-1:0] scan_x,
    output logic [COORD_W-1:0] scan_y,
    input  logic               cover_in,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [COLOR_W-1:0] wr_data,
    output logic               busy,
    output logic               job_done
);

    localparam int DRAIN_CYCLES = FILL_LATENCY + 2;
    localparam int DCW          = $clog2(DRAIN_CYCLES + 1);
    localparam logic [ADDR_W-1:0] FW_A = ADDR_W'(FRAME_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [COORD_W-1:0] x, y, x0, x1, y0, y1;
    logic [COLOR_W-1:0] color;
    logic               clr;
    logic [DCW-1:0]     drain_cnt;
    logic               drain_last;
    logic               accept;
    logic               last_pixel;

    // Scan window derived from the offered job; only captured on accept.
    logic [COORD_W-1:0] wx0, wx1, wy0, wy1;
    logic               win_empty;

`ifdef RASTER_SCAN_BBOX_CLIP_EN
    localparam logic [COORD_W-1:0] XLIM = COORD_W'(FRAME_WIDTH - 1);
    localparam logic [COORD_W-1:0] YLIM = COORD_W'(FRAME_HEIGHT - 1);

    // Clamp the inclusive bounding box to the frame; an inverted result means nothing to scan.
    always_comb begin
        wx0       = job_xmin;
        wy0       = job_ymin;
        wx1       = (job_xmax > XLIM) ? XLIM : job_xmax;
        wy1       = (job_ymax > YLIM) ? YLIM : job_ymax;
        win_empty = (wx0 > wx1) || (wy0 > wy1);
    end
`else
    logic unused_bbox;

    // Full-frame sweep; the bounding-box inputs play no part in this build.
    always_comb begin
        wx0       = '0;
        wy0       = '0;
        wx1       = COORD_W'(FRAME_WIDTH - 1);
        wy1       = COORD_W'(FRAME_HEIGHT - 1);
        win_empty = 1'b0;
    end

    assign unused_bbox = ^{job_xmin, job_xmax, job_ymin, job_ymax};
`endif

    assign accept     = (state == IDLE) && job_valid;
    assign last_pixel = (x == x1) && (y == y1);
    assign drain_last = (drain_cnt == DCW'(DRAIN_CYCLES - 1));
    assign scan_x     = x;
    assign scan_y     = y;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake/status outputs.
    always_comb begin
        state_nxt  = state;
        job_ready  = 1'b0;
        busy       = 1'b0;
        scan_valid = 1'b0;
        job_done   = 1'b0;
        case (state)
            IDLE: begin
                job_ready = 1'b1;
                if (job_valid) begin
                    state_nxt = win_empty ? DRAIN : SCAN;
                end
            end
            SCAN: begin
                busy       = 1'b1;
                scan_valid = 1'b1;
                if (last_pixel) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_last) begin
                    job_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Job capture, raster walk (x fastest, wrapping to x0) and drain timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            x0        <= '0;
            x1        <= '0;
            y0        <= '0;
            y1        <= '0;
            color     <= '0;
            clr       <= 1'b0;
            drain_cnt <= '0;
        end else begin
            if (accept) begin
                x0    <= wx0;
                x1    <= wx1;
                y0    <= wy0;
                y1    <= wy1;
                x     <= wx0;
                y     <= wy0;
                color <= job_color;
                clr   <= job_clear;
            end else if (state == SCAN) begin
                if (x == x1) begin
                    x <= x0;
                    if (y != y1) begin
                        y <= y + 1'b1;
                    end
                end else begin
                    x <= x + 1'b1;
                end
            end
            if (state == DRAIN) begin
                drain_cnt <= drain_cnt + 1'b1;
            end else begin
                drain_cnt <= '0;
            end
        end
    end

    // Alignment pipeline: the tail stage holds the pixel whose coverage is on cover_in this cycle.
    logic [ADDR_W-1:0]       issue_addr;
    logic [FILL_LATENCY-1:0] pv;
    logic [FILL_LATENCY-1:0] pc;
    logic [ADDR_W-1:0]       pa [FILL_LATENCY];
    logic [COLOR_W-1:0]      pd [FILL_LATENCY];
    logic                    wr_hit;

    assign issue_addr = ADDR_W'(y) * FW_A + ADDR_W'(x);
    assign wr_hit     = pv[FILL_LATENCY-1] && (pc[FILL_LATENCY-1] || cover_in);

    // Delay line for valid/clear/address/colour; reset empties it so an aborted job writes nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            pv <= '0;
            pc <= '0;
            for (int i = 0; i < FILL_LATENCY; i++) begin
                pa[i] <= '0;
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= scan_valid;
            pc[0] <= clr;
            pa[0] <= issue_addr;
            pd[0] <= color;
            for (int i = 1; i < FILL_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                pc[i] <= pc[i-1];
                pa[i] <= pa[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    // Registered framebuffer write port; data is forced to zero on empty slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en   <= wr_hit;
            wr_addr <= pa[FILL_LATENCY-1];
            wr_data <= wr_hit ? pd[FILL_LATENCY-1] : '0;
        end
    end

endmodule

// File: tb/tb_raster_scan_writer.sv
// Bench for raster_scan_writer on an 8x4 frame with coverage latency 3.
// Expected writes are queued when a job is launched and retired by the write monitor.
// Builds with or without RASTER_SCAN_BBOX_CLIP_EN; the clipping scenarios only exist in the former.
module tb_raster_scan_writer;

    localparam int FW = 8;
    localparam int FH = 4;
    localparam int LAT = 3;
    localparam int AW = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic        job_clear = 1'b0;
    logic [15:0] job_color = '0;
    logic [15:0] job_xmin = '0;
    logic [15:0] job_xmax = '0;
    logic [15:0] job_ymin = '0;
    logic [15:0] job_ymax = '0;
    logic        scan_valid;
    logic [15:0] scan_x;
    logic [15:0] scan_y;
    logic        cover_in = 1'b0;
    logic        wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        job_done;

    raster_scan_writer #(
        .FRAME_WIDTH (FW),
        .FRAME_HEIGHT(FH),
        .COORD_W     (16),
        .COLOR_W     (16),
        .FILL_LATENCY(LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .job_valid (job_valid),
        .job_ready (job_ready),
        .job_clear (job_clear),
        .job_color (job_color),
        .job_xmin  (job_xmin),
        .job_xmax  (job_xmax),
        .job_ymin  (job_ymin),
        .job_ymax  (job_ymax),
        .scan_valid(scan_valid),
        .scan_x    (scan_x),
        .scan_y    (scan_y),
        .cover_in  (cover_in),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .job_done  (job_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [15:0]   d;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int wr_count = 0;
    int scan_count = 0;
    int done_count = 0;
    int first_wr = -1;
    int last_wr = -1;
    int idle_data_nz = 0;
    int mode = 0;   // coverage unit model: 0 = never, 1 = only row 1, 2 = always

    logic        hv [LAT+1];
    logic [15:0] hy [LAT+1];

    always @(posedge clk) cyc <= cyc + 1;

    // Coverage unit model plus write monitor; everything sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        for (int k = LAT; k > 0; k--) begin
            hv[k] = hv[k-1];
            hy[k] = hy[k-1];
        end
        hv[0] = scan_valid;
        hy[0] = scan_y;
        case (mode)
            1:       cover_in = (hv[LAT] === 1'b1) && (hy[LAT] == 16'd1);
            2:       cover_in = 1'b1;
            default: cover_in = 1'b0;
        endcase

        if (wr_en === 1'b1) begin
            wr_count++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL wr_unexpected: got addr=%0d data=%h, no write expected (cyc %0d)", wr_addr, wr_data, cyc);
            end else begin
                e = exp_q.pop_front();
                if (wr_addr !== e.a || wr_data !== e.d) begin
                    n_bad++;
                    $display("FAIL wr_beat: got addr=%0d data=%h, want addr=%0d data=%h (cyc %0d)", wr_addr, wr_data, e.a, e.d, cyc);
                end
            end
        end else if (rst === 1'b0 && wr_data !== 16'h0000) begin
            idle_data_nz++;
        end
        if (job_done === 1'b1) done_count++;
        if (scan_valid === 1'b1) scan_count++;
    end

    task automatic clear_counts();
        wr_count = 0;
        scan_count = 0;
        done_count = 0;
        first_wr = -1;
        last_wr = -1;
    endtask

    task automatic push_range(input int a0, input int a1, input logic [15:0] col);
        exp_t e;
        for (int a = a0; a <= a1; a++) begin
            e.a = AW'(a);
            e.d = col;
            exp_q.push_back(e);
        end
    endtask

    // Offer one job, wait for accept and job_done; unobserved events come back as -1.
    task automatic run_job(input logic clr, input logic [15:0] col,
                           input logic [15:0] xmn, input logic [15:0] xmx,
                           input logic [15:0] ymn, input logic [15:0] ymx,
                           output int acc, output int done);
        acc = -1;
        done = -1;
        @(negedge clk);
        job_clear = clr;
        job_color = col;
        job_xmin = xmn;
        job_xmax = xmx;
        job_ymin = ymn;
        job_ymax = ymx;
        job_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (job_ready === 1'b1) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        job_valid = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (job_done === 1'b1) begin
                done = cyc;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        job_valid = 1'b0;
        mode = 0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({job_ready, busy, scan_valid, wr_en, job_done} !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got ready,busy,scan,wr,done=%b want 10000", {job_ready, busy, scan_valid, wr_en, job_done});
        end
        n_cmp++;
        if ({scan_x, scan_y, wr_addr, wr_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got x=%0d y=%0d addr=%0d data=%h want all 0", scan_x, scan_y, wr_addr, wr_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clear();
        int acc, done;
        clear_counts();
        push_range(0, 31, 16'h0F0F);
        run_job(1'b1, 16'h0F0F, 16'h0, 16'hFFFF, 16'h0, 16'hFFFF, acc, done);
        n_cmp++;
        if (first_wr - acc !== 5) begin
            n_bad++;
            $display("FAIL clear_first_wr: got %0d cycles after accept, want 5", first_wr - acc);
        end
        n_cmp++;
        if (done - acc !== 37 || acc < 0) begin
            n_bad++;
            $display("FAIL clear_done_time: got %0d cycles after accept, want 37", done - acc);
        end
        n_cmp++;
        if (done - last_wr !== 1) begin
            n_bad++;
            $display("FAIL clear_done_after_last: got %0d, want 1", done - last_wr);
        end
        n_cmp++;
        if (wr_count !== 32 || scan_count !== 32) begin
            n_bad++;
            $display("FAIL clear_counts: got writes=%0d scans=%0d want 32/32", wr_count, scan_count);
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL clear_missing: got %0d outstanding, want 0", exp_q.size());
        end
    endtask

    task automatic test_triangle();
        int acc, done;
        clear_counts();
        idle_data_nz = 0;
        mode = 1;
        push_range(8, 15, 16'h1234);
        run_job(1'b0, 16'h1234, 16'h0, 16'hFFFF, 16'h0, 16'hFFFF, acc, done);
        mode = 0;
        n_cmp++;
        if (wr_count !== 8 || exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL tri_writes: got %0d writes, %0d outstanding, want 8/0", wr_count, exp_q.size());
        end
        n_cmp++;
        if (done - acc !== 37 || acc < 0) begin
            n_bad++;
            $display("FAIL tri_done_time: got %0d, want 37", done - acc);
        end
        n_cmp++;
        if (idle_data_nz !== 0) begin
            n_bad++;
            $display("FAIL tri_idle_data: got %0d nonzero wr_data slots, want 0", idle_data_nz);
        end
    endtask

    task automatic test_cover_ignored();
        int acc, done;
        clear_counts();
        mode = 2;
        push_range(0, 31, 16'hBEEF);
        run_job(1'b0, 16'hBEEF, 16'h0, 16'hFFFF, 16'h0, 16'hFFFF, acc, done);
        repeat (8) @(negedge clk);
        mode = 0;
        n_cmp++;
        if (wr_count !== 32 || exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL cover_idle: got %0d writes, %0d outstanding, want 32/0", wr_count, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int acc_a = -1, acc_b = -1, d1 = -1, d2 = -1;
        clear_counts();
        push_range(0, 31, 16'h00AA);
        push_range(0, 31, 16'h00AA);
        @(negedge clk);
        job_clear = 1'b1;
        job_color = 16'h00AA;
        job_xmin = 16'h0;
        job_xmax = 16'hFFFF;
        job_ymin = 16'h0;
        job_ymax = 16'hFFFF;
        job_valid = 1'b1;
        for (int i = 0; i < 300 && d2 < 0; i++) begin
            if (acc_b >= 0) job_valid = 1'b0;
            if (job_valid === 1'b1 && job_ready === 1'b1) begin
                if (acc_a < 0) acc_a = cyc;
                else acc_b = cyc;
            end
            if (job_done === 1'b1) begin
                if (d1 < 0) d1 = cyc;
                else d2 = cyc;
            end
            @(negedge clk);
        end
        job_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (acc_b - d1 !== 1 || d1 < 0) begin
            n_bad++;
            $display("FAIL b2b_accept: got 2nd accept %0d cycles after job_done, want 1", acc_b - d1);
        end
        n_cmp++;
        if (acc_b - acc_a !== 38 || d2 - acc_b !== 37) begin
            n_bad++;
            $display("FAIL b2b_spacing: got accept gap %0d, 2nd job length %0d, want 38/37", acc_b - acc_a, d2 - acc_b);
        end
        n_cmp++;
        if (wr_count !== 64 || exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL b2b_writes: got %0d writes, %0d outstanding, want 64/0", wr_count, exp_q.size());
        end
    endtask

    task automatic test_reset_midjob();
        int acc = -1, done;
        clear_counts();
        push_range(0, 5, 16'h5555);
        @(negedge clk);
        job_clear = 1'b1;
        job_color = 16'h5555;
        job_xmax = 16'hFFFF;
        job_ymax = 16'hFFFF;
        job_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (job_ready === 1'b1) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        job_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({wr_en, busy, job_ready} !== 3'b001) begin
            n_bad++;
            $display("FAIL rst_mid_state: got wr,busy,ready=%b want 001", {wr_en, busy, job_ready});
        end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (done_count !== 0 || scan_count !== 10) begin
            n_bad++;
            $display("FAIL rst_mid_abort: got done pulses=%0d scans=%0d want 0/10", done_count, scan_count);
        end
        n_cmp++;
        if (wr_count !== 6 || exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL rst_mid_writes: got %0d writes, %0d outstanding, want 6/0", wr_count, exp_q.size());
        end
        clear_counts();
        push_range(0, 31, 16'h7777);
        run_job(1'b1, 16'h7777, 16'h0, 16'hFFFF, 16'h0, 16'hFFFF, acc, done);
        n_cmp++;
        if (first_wr - acc !== 5 || done - acc !== 37 || wr_count !== 32 || exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL rst_restart: got first_wr=%0d done=%0d writes=%0d want 5/37/32", first_wr - acc, done - acc, wr_count);
        end
    endtask

`ifdef RASTER_SCAN_BBOX_CLIP_EN
    task automatic test_bbox_clamp();
        int acc, done;
        clear_counts();
        push_range(26, 31, 16'h0A0A);
        run_job(1'b1, 16'h0A0A, 16'd2, 16'd20, 16'd3, 16'd3, acc, done);
        n_cmp++;
        if (wr_count !== 6 || scan_count !== 6 || exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL bbox_clamp: got writes=%0d scans=%0d outstanding=%0d want 6/6/0", wr_count, scan_count, exp_q.size());
        end
        n_cmp++;
        if (done - acc !== 11 || acc < 0) begin
            n_bad++;
            $display("FAIL bbox_clamp_done: got %0d, want 11", done - acc);
        end
    endtask

    task automatic test_bbox_empty();
        int acc, done;
        clear_counts();
        run_job(1'b1, 16'h0B0B, 16'd5, 16'd4, 16'd0, 16'd3, acc, done);
        n_cmp++;
        if (wr_count !== 0 || scan_count !== 0) begin
            n_bad++;
            $display("FAIL bbox_empty: got writes=%0d scans=%0d want 0/0", wr_count, scan_count);
        end
        n_cmp++;
        if (done - acc !== 5 || acc < 0) begin
            n_bad++;
            $display("FAIL bbox_empty_done: got %0d, want 5", done - acc);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_clear();
        test_triangle();
        test_cover_ignored();
        test_back_to_back();
        test_reset_midjob();
`ifdef RASTER_SCAN_BBOX_CLIP_EN
        test_bbox_clamp();
        test_bbox_empty();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
